// File: rtl/result_bus_arbiter_if.sv
// Result-bus bundle: per-unit result offers from the execution units and the
// single registered broadcast toward the reservation stations.
interface result_bus_arbiter_if #(
    parameter int UNITS         = 4,
    parameter int OPERAND_WIDTH = 32,
    parameter int RS_ID_WIDTH   = 5
);
    localparam int UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;

    // Handshake: result u transfers at a clk edge where result_valid[u] && result_ready[u]
    // (and flush is low); result_ready comes from registered state only. The broadcast has
    // no ready: each bus_valid beat lasts one cycle and must be taken by the consumers.
    logic                                flush;
    logic [UNITS-1:0]                    result_valid;
    logic [UNITS-1:0]                    result_ready;
    logic [UNITS-1:0][RS_ID_WIDTH-1:0]   result_rs_id;
    logic [UNITS-1:0][OPERAND_WIDTH-1:0] result_value;
    logic                                bus_valid;
    logic [RS_ID_WIDTH-1:0]              bus_rs_id;
    logic [OPERAND_WIDTH-1:0]            bus_value;
    logic [UNIT_W-1:0]                   bus_unit;

    modport master (
        output flush, result_valid, result_rs_id, result_value,
        input  result_ready, bus_valid, bus_rs_id, bus_value, bus_unit
    );

    modport slave (
        input  flush, result_valid, result_rs_id, result_value,
        output result_ready, bus_valid, bus_rs_id, bus_value, bus_unit
    );
endinterface

// File: rtl/result_bus_arbiter.sv
// Buffers finished results per execution unit (2 deep) and broadcasts one per cycle
// on the registered result bus, picking units round-robin.
module result_bus_arbiter #(
    parameter int UNITS         = 4,
    parameter int OPERAND_WIDTH = 32,
    parameter int RS_ID_WIDTH   = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    result_bus_arbiter_if.slave rb
);
    localparam int UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;

    logic [1:0]               count      [UNITS];
    logic [RS_ID_WIDTH-1:0]   slot_id    [UNITS][2];
    logic [OPERAND_WIDTH-1:0] slot_value [UNITS][2];
    logic [UNIT_W-1:0]        ptr;
    logic [UNIT_W-1:0]        ptr_next;

    logic [UNITS-1:0]  ready;
    logic [UNITS-1:0]  push;
    logic [UNITS-1:0]  pop;
    logic [UNITS-1:0]  wr_slot;
    logic              grant_any;
    logic [UNIT_W-1:0] grant_unit;
    logic [UNIT_W-1:0] cand;

    always_comb begin
        ready = '0;
        for (int u = 0; u < UNITS; u++) begin
            ready[u] = (count[u] != 2'd2);
        end
    end

    assign rb.result_ready = ready;

    // First non-empty unit at or after the pointer, wrapping around.
    always_comb begin
        grant_any  = 1'b0;
        grant_unit = '0;
        cand       = '0;
        for (int k = 0; k < UNITS; k++) begin
            cand = UNIT_W'((int'(ptr) + k) % UNITS);
            if (!grant_any && (count[cand] != 2'd0)) begin
                grant_any  = 1'b1;
                grant_unit = cand;
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (grant_any) begin
            ptr_next = (grant_unit == UNIT_W'(UNITS - 1)) ? '0 : grant_unit + UNIT_W'(1);
        end
    end

    // A push lands behind whatever survives this edge's pop.
    always_comb begin
        push    = '0;
        pop     = '0;
        wr_slot = '0;
        for (int u = 0; u < UNITS; u++) begin
            pop[u]     = grant_any && (grant_unit == UNIT_W'(u));
            push[u]    = rb.result_valid[u] && ready[u];
            wr_slot[u] = (count[u] == 2'd1) && !pop[u];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            rb.bus_valid <= 1'b0;
            rb.bus_rs_id <= '0;
            rb.bus_value <= '0;
            rb.bus_unit  <= '0;
            for (int u = 0; u < UNITS; u++) begin
                count[u] <= 2'd0;
            end
        end else if (rb.flush) begin
            ptr          <= '0;
            rb.bus_valid <= 1'b0;
            for (int u = 0; u < UNITS; u++) begin
                count[u] <= 2'd0;
            end
        end else begin
            ptr          <= ptr_next;
            rb.bus_valid <= grant_any;
            if (grant_any) begin
                rb.bus_rs_id <= slot_id[grant_unit][0];
                rb.bus_value <= slot_value[grant_unit][0];
                rb.bus_unit  <= grant_unit;
            end
            for (int u = 0; u < UNITS; u++) begin
                count[u] <= count[u] + {1'b0, push[u]} - {1'b0, pop[u]};
            end
        end
    end

    // Slot contents need no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (!rb.flush) begin
            for (int u = 0; u < UNITS; u++) begin
                if (pop[u]) begin
                    slot_id[u][0]    <= slot_id[u][1];
                    slot_value[u][0] <= slot_value[u][1];
                end
                if (push[u]) begin
                    slot_id[u][wr_slot[u]]    <= rb.result_rs_id[u];
                    slot_value[u][wr_slot[u]] <= rb.result_value[u];
                end
            end
        end
    end
endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: scenario tasks plus a queue-based reference model
// that is compared against the bus and ready outputs every cycle.
module tb_result_bus_arbiter;
    localparam int UNITS = 4;
    localparam int OW    = 32;
    localparam int RW    = 5;
    localparam int EW    = RW + OW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    result_bus_arbiter_if #(.UNITS(UNITS), .OPERAND_WIDTH(OW), .RS_ID_WIDTH(RW)) rb ();

    result_bus_arbiter #(.UNITS(UNITS), .OPERAND_WIDTH(OW), .RS_ID_WIDTH(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rb    (rb)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q [UNITS][$];
    int            m_ptr;
    logic          m_valid;
    logic [RW-1:0] m_id;
    logic [OW-1:0] m_val;
    logic [1:0]    m_unit;
    int            m_sizes [UNITS];
    int            m_win;
    int            m_cand;
    logic [EW-1:0] m_entry;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < UNITS; u++) exp_q[u].delete();
            m_ptr = 0; m_valid = 1'b0; m_id = '0; m_val = '0; m_unit = '0;
        end else if (rb.flush) begin
            for (int u = 0; u < UNITS; u++) exp_q[u].delete();
            m_ptr = 0; m_valid = 1'b0;
        end else begin
            for (int u = 0; u < UNITS; u++) m_sizes[u] = exp_q[u].size();
            m_win = -1;
            for (int k = 0; k < UNITS; k++) begin
                m_cand = (m_ptr + k) % UNITS;
                if (m_win < 0 && m_sizes[m_cand] > 0) m_win = m_cand;
            end
            m_valid = (m_win >= 0);
            if (m_win >= 0) begin
                m_entry = exp_q[m_win].pop_front();
                m_id    = m_entry[EW-1:OW];
                m_val   = m_entry[OW-1:0];
                m_unit  = 2'(m_win);
                m_ptr   = (m_win + 1) % UNITS;
            end
            for (int u = 0; u < UNITS; u++) begin
                if (rb.result_valid[u] && m_sizes[u] < 2)
                    exp_q[u].push_back({rb.result_rs_id[u], rb.result_value[u]});
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic             mon_en = 1'b0;
    logic [UNITS-1:0] exp_ready;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int u = 0; u < UNITS; u++) exp_ready[u] = (exp_q[u].size() != 2);
            checks++;
            if ({rb.bus_valid, rb.bus_rs_id, rb.bus_value, rb.bus_unit} !== {m_valid, m_id, m_val, m_unit}) begin
                errors++;
                $display("FAIL model_bus @%0t: got v=%0b id=%0d val=%h unit=%0d, expected v=%0b id=%0d val=%h unit=%0d",
                         $time, rb.bus_valid, rb.bus_rs_id, rb.bus_value, rb.bus_unit, m_valid, m_id, m_val, m_unit);
            end
            checks++;
            if (rb.result_ready !== exp_ready) begin
                errors++;
                $display("FAIL model_ready @%0t: got %b expected %b", $time, rb.result_ready, exp_ready);
            end
        end
    end

    // ---------------- driver ----------------
    logic [RW-1:0]    next_tag [UNITS];
    int               sent     [UNITS];
    int               quota    [UNITS];
    logic [UNITS-1:0] last_valid = '0;
    logic [UNITS-1:0] last_ready = '0;

    task automatic init_drive();
        for (int u = 0; u < UNITS; u++) begin
            next_tag[u] = '0;
            sent[u]     = 0;
            quota[u]    = 1000;
        end
    endtask

    // Wait for the next falling edge, book the previous offer, then present new offers.
    task automatic step(input logic [UNITS-1:0] mask);
        @(negedge clk);
        for (int u = 0; u < UNITS; u++) begin
            if (last_valid[u] && last_ready[u] && !rb.flush) begin
                next_tag[u] = next_tag[u] + 1'b1;
                sent[u]++;
            end
        end
        rb.flush = 1'b0;
        for (int u = 0; u < UNITS; u++) begin
            rb.result_valid[u] = mask[u] && (sent[u] < quota[u]);
            rb.result_rs_id[u] = next_tag[u];
            rb.result_value[u] = $urandom();
        end
        last_valid = rb.result_valid;
        last_ready = rb.result_ready;
    endtask

    task automatic flush_now();
        step('0);
        rb.flush = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        rb.flush = 1'b0;
        rb.result_valid = '0;
        rb.result_rs_id = '0;
        rb.result_value = '0;
        init_drive();
        repeat (3) @(negedge clk);
        checks++;
        if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rb.bus_valid); end
        checks++;
        if (rb.bus_rs_id !== '0) begin errors++; $display("FAIL reset_rs_id: got %0d expected 0", rb.bus_rs_id); end
        checks++;
        if (rb.bus_value !== '0) begin errors++; $display("FAIL reset_value: got %h expected 0", rb.bus_value); end
        checks++;
        if (rb.bus_unit !== '0) begin errors++; $display("FAIL reset_unit: got %0d expected 0", rb.bus_unit); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rb.result_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b expected 1111", rb.result_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        init_drive();
        next_tag[2] = 5'd5;
        step(4'b0100);
        rb.result_value[2] = 32'hDEADBEEF;
        step('0);
        checks++;
        if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL single_t1: bus_valid got %0b expected 0", rb.bus_valid); end
        step('0);
        checks++;
        if ({rb.bus_valid, rb.bus_rs_id, rb.bus_value, rb.bus_unit} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd2}) begin
            errors++;
            $display("FAIL single_t2: got v=%0b id=%0d val=%h unit=%0d expected v=1 id=5 val=deadbeef unit=2",
                     rb.bus_valid, rb.bus_rs_id, rb.bus_value, rb.bus_unit);
        end
        step('0);
        checks++;
        if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL single_t3: bus_valid got %0b expected 0", rb.bus_valid); end
    endtask

    task automatic test_round_robin();
        init_drive();
        flush_now();
        for (int wave = 0; wave < 2; wave++) begin
            for (int u = 0; u < UNITS; u++) next_tag[u] = 5'(8 + u);
            step(4'hF);
            step('0);
            checks++;
            if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL rr_idle wave %0d: bus_valid got %0b expected 0", wave, rb.bus_valid); end
            for (int k = 0; k < UNITS; k++) begin
                step('0);
                checks++;
                if ({rb.bus_valid, rb.bus_rs_id, rb.bus_unit} !== {1'b1, 5'(8 + k), 2'(k)}) begin
                    errors++;
                    $display("FAIL rr_order wave %0d slot %0d: got v=%0b id=%0d unit=%0d expected v=1 id=%0d unit=%0d",
                             wave, k, rb.bus_valid, rb.bus_rs_id, rb.bus_unit, 8 + k, k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_next [2];
        int got [2];
        int last_unit;
        logic saw_low;
        init_drive();
        flush_now();
        next_tag[0] = 5'd0;  next_tag[1] = 5'd16;
        exp_next[0] = 0;     exp_next[1] = 16;
        got[0] = 0; got[1] = 0;
        last_unit = -1;
        saw_low = 1'b0;
        for (int c = 0; c < 22; c++) begin
            step((c < 16) ? 4'b0011 : 4'b0000);
            if (c < 4 && rb.result_ready[0] === 1'b0) saw_low = 1'b1;
            if (rb.bus_valid === 1'b1) begin
                checks++;
                if (rb.bus_unit > 2'd1) begin
                    errors++;
                    $display("FAIL bp_unit: got unit %0d expected 0 or 1", rb.bus_unit);
                end else begin
                    checks++;
                    if (int'(rb.bus_rs_id) != exp_next[rb.bus_unit]) begin
                        errors++;
                        $display("FAIL bp_tag unit %0d: got %0d expected %0d", rb.bus_unit, rb.bus_rs_id, exp_next[rb.bus_unit]);
                    end
                    exp_next[rb.bus_unit]++;
                    got[rb.bus_unit]++;
                    if (c < 16 && last_unit >= 0) begin
                        checks++;
                        if (int'(rb.bus_unit) == last_unit) begin
                            errors++;
                            $display("FAIL bp_alternate: unit %0d twice in a row, expected %0d", rb.bus_unit, 1 - last_unit);
                        end
                    end
                    last_unit = int'(rb.bus_unit);
                end
            end
        end
        checks++;
        if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_ready_drop: ready[0] low seen=%0b expected 1", saw_low); end
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (got[u] != sent[u] || sent[u] < 6) begin
                errors++;
                $display("FAIL bp_count unit %0d: broadcast %0d accepted %0d (expected equal, at least 6)", u, got[u], sent[u]);
            end
        end
    endtask

    task automatic test_full_buffer();
        int exp3;
        init_drive();
        flush_now();
        next_tag[3] = 5'd1;
        next_tag[0] = 5'd20;
        quota[3] = 3;
        exp3 = 1;
        for (int c = 0; c < 18; c++) begin
            step((c < 10) ? 4'b1001 : 4'b0000);
            if (c == 2) begin
                checks++;
                if (rb.result_ready[3] !== 1'b0) begin errors++; $display("FAIL full_ready3: got %0b expected 0", rb.result_ready[3]); end
            end
            if (c == 3) begin
                checks++;
                if (sent[3] != 2) begin errors++; $display("FAIL full_hold: unit 3 accepted %0d expected 2", sent[3]); end
            end
            if (c == 4) begin
                checks++;
                if (sent[3] != 3) begin errors++; $display("FAIL full_accept3: unit 3 accepted %0d expected 3", sent[3]); end
            end
            if (rb.bus_valid === 1'b1 && rb.bus_unit === 2'd3) begin
                checks++;
                if (int'(rb.bus_rs_id) != exp3) begin errors++; $display("FAIL full_order3: got %0d expected %0d", rb.bus_rs_id, exp3); end
                exp3++;
            end
        end
        checks++;
        if (exp3 != 4) begin errors++; $display("FAIL full_count3: unit 3 broadcasts %0d expected 3", exp3 - 1); end
    endtask

    task automatic test_flush();
        init_drive();
        flush_now();
        for (int u = 0; u < UNITS; u++) next_tag[u] = 5'(12 + 4 * u);
        step(4'hF);
        step(4'b0110);
        checks++;
        if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL flush_pre: bus_valid got %0b expected 0", rb.bus_valid); end
        step(4'b1000);
        rb.flush = 1'b1;
        checks++;
        if ({rb.bus_valid, rb.bus_rs_id, rb.bus_unit} !== {1'b1, 5'd12, 2'd0}) begin
            errors++;
            $display("FAIL flush_first: got v=%0b id=%0d unit=%0d expected v=1 id=12 unit=0", rb.bus_valid, rb.bus_rs_id, rb.bus_unit);
        end
        step('0);
        checks++;
        if (rb.result_ready !== 4'hF) begin errors++; $display("FAIL flush_ready: got %b expected 1111", rb.result_ready); end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet cycle %0d: bus_valid got %0b expected 0", c, rb.bus_valid); end
            step('0);
        end
    endtask

    task automatic test_async_reset();
        init_drive();
        next_tag[1] = 5'd7;
        next_tag[2] = 5'd9;
        step(4'b0110);
        step(4'b0110);
        step('0);
        checks++;
        if ({rb.bus_valid, rb.bus_rs_id, rb.bus_unit} !== {1'b1, 5'd7, 2'd1}) begin
            errors++;
            $display("FAIL areset_pre: got v=%0b id=%0d unit=%0d expected v=1 id=7 unit=1", rb.bus_valid, rb.bus_rs_id, rb.bus_unit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rb.bus_valid, rb.bus_rs_id, rb.bus_value, rb.bus_unit} !== '0) begin
            errors++;
            $display("FAIL areset_now: got v=%0b id=%0d val=%h unit=%0d expected all 0", rb.bus_valid, rb.bus_rs_id, rb.bus_value, rb.bus_unit);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_valid = '0;
        #1;
        checks++;
        if (rb.result_ready !== 4'hF) begin errors++; $display("FAIL areset_ready: got %b expected 1111", rb.result_ready); end
        init_drive();
        next_tag[3] = 5'd21;
        step(4'b1000);
        step('0);
        checks++;
        if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL areset_t1: bus_valid got %0b expected 0", rb.bus_valid); end
        step('0);
        checks++;
        if ({rb.bus_valid, rb.bus_rs_id, rb.bus_unit} !== {1'b1, 5'd21, 2'd3}) begin
            errors++;
            $display("FAIL areset_t2: got v=%0b id=%0d unit=%0d expected v=1 id=21 unit=3", rb.bus_valid, rb.bus_rs_id, rb.bus_unit);
        end
        step('0);
        checks++;
        if (rb.bus_valid !== 1'b0) begin errors++; $display("FAIL areset_t3: bus_valid got %0b expected 0", rb.bus_valid); end
    endtask

    task automatic test_random();
        init_drive();
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 19) == 0) rb.flush = 1'b1;
        end
        repeat (8) step('0);
        checks++;
        if (rb.bus_valid !== 1'b0 || rb.result_ready !== 4'hF) begin
            errors++;
            $display("FAIL random_drain: got v=%0b ready=%b expected v=0 ready=1111", rb.bus_valid, rb.result_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_full_buffer();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
- Collects finished results from the execution units that sit downstream of the reservation stations and broadcasts them one per cycle on the shared result bus.
- The result bus feeds the reservation stations' operand-update ports and their slot-release logic.
- Each unit gets a 2-entry buffer. Unit buffers are served round-robin so that no unit starves.
- The broadcast is registered, giving a glitch-free, single-cycle-valid bus.

Parameters:
- UNITS, 4, number of execution units feeding the bus
- OPERAND_WIDTH, 32, bit width of a result value
- RS_ID_WIDTH, 5, bit width of the system-wide reservation station ID tag

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous flush; discards all buffered and pending results
- result_valid[0:UNITS-1]  in  1 each  unit u offers a result
- result_ready[0:UNITS-1]  out  1 each  buffer of unit u can accept
- result_rs_id[0:UNITS-1]  in  RS_ID_WIDTH each  tag of the reservation station that produced the result
- result_value[0:UNITS-1]  in  OPERAND_WIDTH each  result data
- bus_valid  out  1  broadcast valid this cycle
- bus_rs_id  out  RS_ID_WIDTH  broadcast tag
- bus_value  out  OPERAND_WIDTH  broadcast data
- bus_unit  out  $clog2(UNITS) (min 1)  index of the source unit, for debug/perf counters

Behaviour:
- Reset (rst_n low, asynchronous):
  - all buffers empty; round-robin pointer = 0
  - bus_valid = 0, bus_rs_id = 0, bus_value = 0, bus_unit = 0
  - result_ready = 1 for every unit as soon as reset deasserts
- Per-unit buffer:
  - 2-entry FIFO with count 0..2.
  - result_ready[u] = (count[u] != 2). It depends only on registered state; there is no combinational path from any input.
  - Push when result_valid[u] & result_ready[u] at a clk edge.
  - Order within a unit is preserved.
- Arbitration (combinational on buffer heads):
  - Candidates are the units with count > 0.
  - The search starts at pointer p and wraps: p, p+1, …, UNITS-1, 0, …, p-1. The first non-empty unit wins.
  - On a grant to u: pop the head of u, and set pointer = (u+1) mod UNITS at the same edge.
  - No grant: pointer unchanged.
- Bus register:
  - At every edge: bus_valid <= grant_exists.
  - On a grant: bus_rs_id, bus_value and bus_unit load the winner's head.
  - Without a grant they hold their old values; only bus_valid drops.
  - The bus has no backpressure; every broadcast is consumed in its valid cycle.
- Latency:
  - A result pushed at edge t into an empty buffer, with no contention, is broadcast with bus_valid high from edge t+1 to t+2.
  - Throughput is one result per cycle in aggregate.
- Simultaneous push and pop on the same unit with count = 2:
  - ready is 0, so no push occurs; the pop reduces count to 1.
  - With count = 1, push and pop in the same cycle leave count = 1; the new entry becomes the head.
- Flush:
  - When flush = 1 at an edge, all counts go to 0, bus_valid <= 0, and the pointer resets to 0.
  - Pushes in that cycle are dropped.
  - Flush takes priority over push, pop and grant.
- Reset mid-operation: asserting rst_n low immediately clears bus_valid and empties all buffers; in-flight results are lost.
- Each tag appears on the bus exactly once per accepted result. No duplication or reordering within a unit.

Test Plan:
1. Single result:
   - Stimulus: after reset, unit 2 presents rs_id=5, value=0xDEADBEEF for one cycle at edge t.
   - Required: bus_valid=1 only during t+1..t+2 with bus_rs_id=5, bus_value=0xDEADBEEF, bus_unit=2; bus_valid=0 otherwise.
2. Round-robin:
   - Stimulus: all 4 units push one result each at the same edge (tags 8, 9, 10, 11).
   - Required: broadcasts on 4 consecutive cycles in order 8, 9, 10, 11; pointer ends at 0.
   - Stimulus: a second simultaneous wave with pointer at 0.
   - Required: same order again.
3. Backpressure:
   - Stimulus: units 0 and 1 hold result_valid high continuously with incrementing tags.
   - Required: the bus alternates units 0/1/0/1; each unit's tags appear in increasing order.
   - Required: result_ready[0] drops to 0 within 3 cycles and never causes a lost or duplicated tag.
4. Full buffer:
   - Stimulus: unit 3 pushes tags 1, 2, 3 on consecutive edges while unit 0 floods with the pointer favouring unit 0.
   - Required: result_ready[3]=0 once count[3]=2; tag 3 is accepted only after a unit-3 pop; the bus shows 1, 2, 3 in order for unit 3.
5. Flush:
   - Stimulus: with 5 results buffered, assert flush for one cycle.
   - Required: bus_valid=0 the next cycle and stays 0 with no new pushes; all result_ready=1; none of the 5 tags is broadcast afterwards.
6. Async reset:
   - Stimulus: drop rst_n mid-cycle while bus_valid=1.
   - Required: bus_valid=0 immediately, with no clock edge needed; after release, the first new push is broadcast with 1-edge latency.
